// File: rtl/ps2_cmd_pkg.sv
// Shared scancode constants, mode/pulse enums and key-decoding helpers
// for the PS/2 command decoder.
package ps2_cmd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_MANUAL = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    PULSE_NONE  = 2'd0,
    PULSE_START = 2'd1,
    PULSE_PAUSE = 2'd2,
    PULSE_CLEAR = 2'd3
  } pulse_t;

  // One decoded key event; rpt marks a typematic repeat of the last make.
  typedef struct packed {
    logic       valid;
    logic       ext;
    logic       brk;
    logic       rpt;
    logic [7:0] code;
  } key_event_t;

  // Prefixes and bytes the receiver may emit that never form a key event.
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;

  // Plain (non-extended) keys.
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_P     = 8'h4D;
  localparam logic [7:0] SC_R     = 8'h2D;
  localparam logic [7:0] SC_M     = 8'h3A;
  localparam logic [7:0] SC_N     = 8'h31;
  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_D     = 8'h23;

  // Extended arrow keys.
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  // Bit positions inside the move bitmap.
  localparam logic [1:0] MOVE_LEFT  = 2'd0;
  localparam logic [1:0] MOVE_UP    = 2'd1;
  localparam logic [1:0] MOVE_DOWN  = 2'd2;
  localparam logic [1:0] MOVE_RIGHT = 2'd3;

  // Keyboard self-test, ack, echo, resend and error bytes.
  function automatic logic is_noise(input logic [7:0] code);
    return (code == 8'hAA) || (code == 8'hFA) || (code == 8'hEE) ||
           (code == 8'hFE) || (code == 8'h00) || (code == 8'hFF);
  endfunction

  // Returns {hit, value[3:0]} for the top-row digit keys.
  function automatic logic [4:0] digit_of(input logic [7:0] code);
    logic [4:0] r;
    case (code)
      8'h45:   r = 5'h10;
      8'h16:   r = 5'h11;
      8'h1E:   r = 5'h12;
      8'h26:   r = 5'h13;
      8'h25:   r = 5'h14;
      8'h2E:   r = 5'h15;
      8'h36:   r = 5'h16;
      8'h3D:   r = 5'h17;
      8'h3E:   r = 5'h18;
      8'h46:   r = 5'h19;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  // Returns {hit, bit[1:0]} for WASD (plain) or arrow (extended) keys.
  function automatic logic [2:0] move_of(input logic ext, input logic [7:0] code);
    logic [2:0] r;
    r = 3'b000;
    if (ext) begin
      case (code)
        SC_LEFT:  r = {1'b1, MOVE_LEFT};
        SC_UP:    r = {1'b1, MOVE_UP};
        SC_DOWN:  r = {1'b1, MOVE_DOWN};
        SC_RIGHT: r = {1'b1, MOVE_RIGHT};
        default:  r = 3'b000;
      endcase
    end else begin
      case (code)
        SC_A:    r = {1'b1, MOVE_LEFT};
        SC_W:    r = {1'b1, MOVE_UP};
        SC_S:    r = {1'b1, MOVE_DOWN};
        SC_D:    r = {1'b1, MOVE_RIGHT};
        default: r = 3'b000;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/ps2_key_event.sv
// Folds E0/F0 prefixes into single key events and flags typematic repeats.
// The event is presented combinationally in the cycle of the final byte so
// the decoder can register its reaction with one cycle of latency.
module ps2_key_event
  import ps2_cmd_pkg::*;
(
  input  logic       clk_in,
  input  logic       reset_n,
  input  logic [7:0] scancode,
  input  logic       scancode_valid,
  output key_event_t key_ev
);

  logic       ext_q;
  logic       brk_q;
  logic       last_vld_q;
  logic       last_ext_q;
  logic [7:0] last_code_q;
  logic       is_prefix;
  logic       is_final;

  // Classify the incoming byte and assemble the event it completes.
  always_comb begin
    // NOTE: every signal assigned here gets a value on every path, otherwise a latch is inferred.
    is_prefix     = (scancode == SC_EXT) || (scancode == SC_BRK);
    is_final      = scancode_valid && !is_prefix && !is_noise(scancode);
    key_ev.valid  = is_final;
    key_ev.ext    = ext_q;
    key_ev.brk    = brk_q;
    key_ev.code   = scancode;
    key_ev.rpt    = !brk_q && last_vld_q && (last_code_q == scancode) && (last_ext_q == ext_q);
  end

  // Prefix flags and last-make memory; any break forgets the last make.
  always_ff @(posedge clk_in or negedge reset_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) begin
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      last_vld_q  <= 1'b0;
      last_ext_q  <= 1'b0;
      last_code_q <= 8'h00;
    end else if (scancode_valid && !is_noise(scancode)) begin
      if (scancode == SC_EXT) begin
        ext_q <= 1'b1;
      end else if (scancode == SC_BRK) begin
        brk_q <= 1'b1;
      end else begin
        ext_q <= 1'b0;
        brk_q <= 1'b0;
        if (brk_q) begin
          last_vld_q <= 1'b0;
        end else begin
          last_vld_q  <= 1'b1;
          last_ext_q  <= ext_q;
          last_code_q <= scancode;
        end
      end
    end
  end

endmodule

// File: rtl/ps2_cmd_decoder.sv
// Turns PS/2 key events into a run/pause/manual mode FSM, stretched command
// pulses, a held-direction bitmap and a decimal file-number entry.
module ps2_cmd_decoder
  import ps2_cmd_pkg::*;
#(
  parameter int PULSE_CYCLES = 65535,
  parameter int FILE_DIGITS  = 2,
  parameter int FILE_ID_W    = 16
) (
  input  logic                 clk_in,
  input  logic                 reset_n,
  input  logic [7:0]           scancode,
  input  logic                 scancode_valid,
  output logic                 start,
  output logic                 pause,
  output logic                 clear,
  output logic [1:0]           state,
  output logic [3:0]           move,
  output logic                 modify,
  output logic [FILE_ID_W-1:0] file_id,
  output logic [FILE_ID_W-1:0] entry_val,
  output logic [2:0]           entry_cnt
);

  localparam int CNT_W = 20;

  key_event_t           key_ev;
  state_t               state_q, state_d;
  pulse_t               pulse_req, pulse_sel_q;
  logic [CNT_W-1:0]     pulse_cnt_q;
  logic                 mk_cmd;
  logic                 clr_motion;
  logic [4:0]           dig;
  logic [2:0]           mv;
  logic [FILE_ID_W-1:0] entry_val_q, file_id_q;
  logic [2:0]           entry_cnt_q;
  logic [3:0]           move_q;
  logic                 modify_q;

  ps2_key_event u_key_event (
    .clk_in         (clk_in),
    .reset_n        (reset_n),
    .scancode       (scancode),
    .scancode_valid (scancode_valid),
    .key_ev         (key_ev)
  );

  assign mk_cmd     = key_ev.valid && !key_ev.brk && !key_ev.ext && !key_ev.rpt;
  assign clr_motion = mk_cmd && ((key_ev.code == SC_R) ||
                                 ((key_ev.code == SC_N) && (state_q == ST_MANUAL)));
  assign dig        = digit_of(key_ev.code);
  assign mv         = move_of(key_ev.ext, key_ev.code);

  // Mode register.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next mode and the command pulse requested by this event.
  always_comb begin
    state_d   = state_q;
    pulse_req = PULSE_NONE;
    if (mk_cmd) begin
      case (key_ev.code)
        SC_ENTER: if (state_q == ST_IDLE || state_q == ST_PAUSED) begin
          state_d   = ST_RUN;
          pulse_req = PULSE_START;
        end
        SC_P: if (state_q == ST_RUN) begin
          state_d   = ST_PAUSED;
          pulse_req = PULSE_PAUSE;
        end
        SC_R: begin
          state_d   = ST_IDLE;
          pulse_req = PULSE_CLEAR;
        end
        SC_M: if (state_q == ST_IDLE || state_q == ST_PAUSED) state_d = ST_MANUAL;
        SC_N: if (state_q == ST_MANUAL) state_d = ST_IDLE;
        default: ;
      endcase
    end
  end

  // Pulse outputs: only the most recent command is high while its counter runs.
  always_comb begin
    start = 1'b0;
    pause = 1'b0;
    clear = 1'b0;
    if (pulse_cnt_q != '0) begin
      case (pulse_sel_q)
        PULSE_START: start = 1'b1;
        PULSE_PAUSE: pause = 1'b1;
        PULSE_CLEAR: clear = 1'b1;
        default:     ;
      endcase
    end
  end

  // Pulse stretcher; a new command reloads the count and replaces the selector.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      pulse_cnt_q <= '0;
      pulse_sel_q <= PULSE_NONE;
    end else if (pulse_req != PULSE_NONE) begin
      pulse_cnt_q <= CNT_W'(PULSE_CYCLES);
      pulse_sel_q <= pulse_req;
    end else if (pulse_cnt_q != '0) begin
      pulse_cnt_q <= pulse_cnt_q - 1'b1;
    end
  end

  // File-number entry and commit on start.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      entry_val_q <= '0;
      entry_cnt_q <= '0;
      file_id_q   <= '0;
    end else if (mk_cmd && (key_ev.code == SC_R || key_ev.code == SC_BKSP)) begin
      entry_val_q <= '0;
      entry_cnt_q <= '0;
    end else if (pulse_req == PULSE_START) begin
      if (entry_cnt_q != '0) file_id_q <= entry_val_q;
      entry_val_q <= '0;
      entry_cnt_q <= '0;
    end else if (mk_cmd && dig[4] && state_q != ST_RUN && entry_cnt_q < 3'(FILE_DIGITS)) begin
      entry_val_q <= FILE_ID_W'(32'(entry_val_q) * 32'd10 + 32'(dig[3:0]));
      entry_cnt_q <= entry_cnt_q + 3'd1;
    end
  end

  // Held directions and modify, tracked only while in MANUAL.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      move_q   <= '0;
      modify_q <= 1'b0;
    end else if (clr_motion) begin
      move_q   <= '0;
      modify_q <= 1'b0;
    end else if (key_ev.valid && state_q == ST_MANUAL) begin
      if (mv[2]) move_q[mv[1:0]] <= !key_ev.brk;
      if (!key_ev.ext && key_ev.code == SC_SPACE) modify_q <= !key_ev.brk;
    end
  end

  assign state     = state_q;
  assign move      = move_q;
  assign modify    = modify_q;
  assign file_id   = file_id_q;
  assign entry_val = entry_val_q;
  assign entry_cnt = entry_cnt_q;

endmodule
